// File: rtl/alu_issue_ctrl.sv
// Operand-fetch / issue / writeback controller around the ALU with an 8-entry register file.
// One instruction in flight at a time: IDLE -> READ -> EXEC -> WB, one instruction per 4 cycles.
module alu_issue_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [2:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_select,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_c_out,
  output logic             done,
  output logic             err,
  output logic             carry_flag,
  output logic             zero_flag
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  localparam logic [2:0] OP_ADD = 3'd5;

  state_t           state, state_nxt;
  logic [2:0]       op_p0, rd_p0, rs1_p0, rs2_p0;
  logic [WIDTH-1:0] a_p1, b_p1;
  logic [2:0]       sel_p1;
  logic [WIDTH-1:0] res_p2;
  logic             c_p2;
  logic [WIDTH-1:0] regfile [8];
  logic             accept;
  logic             instr_unused;

  function automatic logic is_illegal(input logic [2:0] op);
    return op == 3'd7;
  endfunction

  assign instr_ready  = (state == IDLE);
  assign accept       = instr_valid & instr_ready;
  assign instr_unused = ^instr[3:0];
  assign rd_data      = regfile[rd_addr];
  assign alu_a        = a_p1;
  assign alu_b        = b_p1;
  assign alu_select   = sel_p1;
  assign done         = (state == WB);
  assign err          = done & is_illegal(op_p0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_p0      <= '0;
      rd_p0      <= '0;
      rs1_p0     <= '0;
      rs2_p0     <= '0;
      a_p1       <= '0;
      b_p1       <= '0;
      sel_p1     <= '0;
      res_p2     <= '0;
      c_p2       <= 1'b0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
      for (int i = 0; i < 8; i++) regfile[i] <= '0;
    end else begin
      state <= state_nxt;
      // p0: decode fields captured on the accept edge
      if (accept) {op_p0, rd_p0, rs1_p0, rs2_p0} <= instr[15:4];
      // Host writes only land in IDLE, so READ after a same-cycle handshake sees them
      if (state == IDLE && wr_en) regfile[wr_addr] <= wr_data;
      // p1: operands and select held stable to the ALU through EXEC and beyond
      if (state == READ) begin
        a_p1   <= regfile[rs1_p0];
        b_p1   <= regfile[rs2_p0];
        sel_p1 <= op_p0;
      end
      // p2: ALU outputs captured at the end of EXEC
      if (state == EXEC) begin
        res_p2 <= alu_result;
        c_p2   <= alu_c_out;
      end
      if (state == WB && !is_illegal(op_p0)) begin
        regfile[rd_p0] <= res_p2;
        zero_flag      <= (res_p2 == '0);
        if (op_p0 == OP_ADD) carry_flag <= c_p2;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU closing the loop.
module tb_alu_issue_ctrl;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             instr_valid;
  logic [15:0]      instr;
  logic             instr_ready;
  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [2:0]       rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [2:0]       alu_select;
  logic             alu_c_out;
  logic             done, err, carry_flag, zero_flag;

  int n_total = 0;
  int n_pass  = 0;

  alu_issue_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_result(alu_result),
    .alu_c_out(alu_c_out), .done(done), .err(err), .carry_flag(carry_flag), .zero_flag(zero_flag)
  );

  always #5 clk = ~clk;

  // Reference ALU: 0 NOT, 1 MOV, 2 OR, 3 AND, 4 SUB, 5 ADD, 6 SLT (signed), 7 unused
  always_comb begin
    alu_result = '0;
    alu_c_out  = 1'b0;
    case (alu_select)
      3'd0: alu_result = ~alu_a;
      3'd1: alu_result = alu_a;
      3'd2: alu_result = alu_a | alu_b;
      3'd3: alu_result = alu_a & alu_b;
      3'd4: alu_result = alu_a - alu_b;
      3'd5: {alu_c_out, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd6: alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, rd, rs1, rs2);
    return {op, rd, rs1, rs2, 4'h0};
  endfunction

  task automatic host_write(input logic [2:0] addr, input logic [31:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    step();
    wr_en = 1'b0;
  endtask

  task automatic reg_chk(input string tag, input logic [2:0] addr, input logic [31:0] exp);
    rd_addr = addr;
    #1;
    chk(tag, rd_data, exp);
  endtask

  // Issues one instruction, checks done latency/err, and returns in IDLE after writeback.
  task automatic run_op(input string tag, input logic [2:0] op, rd, rs1, rs2, input logic exp_err);
    int lat;
    instr_valid = 1'b1;
    instr = mk(op, rd, rs1, rs2);
    step();
    instr_valid = 1'b0;
    wr_en = 1'b0;
    lat = 1;
    while (!done && lat < 10) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    step();
    chk({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
    chk({tag, "_done_low"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_flags", {30'd0, carry_flag, zero_flag}, 32'd0);
    chk("rst_sel", {29'd0, alu_select}, 32'd0);
    chk("rst_a", alu_a, 32'd0);

    // 1: ADD r3 = 5 + 3
    host_write(3'd1, 32'd5);
    host_write(3'd2, 32'd3);
    run_op("add1", 3'd5, 3'd3, 3'd1, 3'd2, 1'b0);
    reg_chk("add1_r3", 3'd3, 32'd8);
    chk("add1_flags", {30'd0, carry_flag, zero_flag}, 32'd0);

    // 2: ADD with carry-out to zero, then SUB leaves carry alone
    host_write(3'd1, 32'hFFFF_FFFF);
    host_write(3'd2, 32'd1);
    run_op("add2", 3'd5, 3'd4, 3'd1, 3'd2, 1'b0);
    reg_chk("add2_r4", 3'd4, 32'd0);
    chk("add2_flags", {30'd0, carry_flag, zero_flag}, 32'd3);
    run_op("sub", 3'd4, 3'd5, 3'd2, 3'd2, 1'b0);
    reg_chk("sub_r5", 3'd5, 32'd0);
    chk("sub_flags", {30'd0, carry_flag, zero_flag}, 32'd3);

    // 3: SLT, NOT, MOV
    host_write(3'd1, 32'd5);
    host_write(3'd2, 32'd3);
    run_op("slt", 3'd6, 3'd6, 3'd2, 3'd1, 1'b0);
    reg_chk("slt_r6", 3'd6, 32'd1);
    chk("slt_flags", {30'd0, carry_flag, zero_flag}, 32'd2);
    run_op("not", 3'd0, 3'd7, 3'd1, 3'd0, 1'b0);
    reg_chk("not_r7", 3'd7, 32'hFFFF_FFFA);
    run_op("mov", 3'd1, 3'd0, 3'd1, 3'd0, 1'b0);
    reg_chk("mov_r0", 3'd0, 32'd5);

    // Host write in the same cycle as the handshake is visible to READ
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'd9;
    run_op("wrsame", 3'd1, 3'd0, 3'd1, 3'd0, 1'b0);
    reg_chk("wrsame_r0", 3'd0, 32'd9);

    // 4: illegal op, zero_flag set beforehand to see it held
    run_op("subz", 3'd4, 3'd5, 3'd1, 3'd1, 1'b0);
    chk("subz_flags", {30'd0, carry_flag, zero_flag}, 32'd3);
    run_op("ill", 3'd7, 3'd1, 3'd2, 3'd2, 1'b1);
    reg_chk("ill_r1", 3'd1, 32'd9);
    chk("ill_flags", {30'd0, carry_flag, zero_flag}, 32'd3);

    // 5: back-to-back instructions with instr_valid held; write during EXEC dropped
    host_write(3'd1, 32'd5);
    instr_valid = 1'b1;
    instr = mk(3'd5, 3'd3, 3'd1, 3'd2);
    step();
    instr = mk(3'd2, 3'd4, 3'd1, 3'd2);
    chk("q_ready_read", {31'd0, instr_ready}, 32'd0);
    step();
    chk("q_ready_exec", {31'd0, instr_ready}, 32'd0);
    chk("q_exec_a", alu_a, 32'd5);
    chk("q_exec_b", alu_b, 32'd3);
    chk("q_exec_sel", {29'd0, alu_select}, 32'd5);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'd100;
    step();
    wr_en = 1'b0;
    chk("q_ready_wb", {31'd0, instr_ready}, 32'd0);
    chk("q_done_wb", {31'd0, done}, 32'd1);
    step();
    chk("q_ready_idle", {31'd0, instr_ready}, 32'd1);
    reg_chk("q_r3", 3'd3, 32'd8);
    step();
    chk("q_second_accepted", {31'd0, instr_ready}, 32'd0);
    instr_valid = 1'b0;
    step();
    chk("q_b_unchanged", alu_b, 32'd3);
    chk("q_sel2", {29'd0, alu_select}, 32'd2);
    step();
    chk("q_done2", {31'd0, done}, 32'd1);
    step();
    reg_chk("q_r4", 3'd4, 32'd7);
    reg_chk("q_r2", 3'd2, 32'd3);
    chk("q_sel_hold", {29'd0, alu_select}, 32'd2);

    // 6: reset during EXEC discards the op
    instr_valid = 1'b1;
    instr = mk(3'd5, 3'd3, 3'd1, 3'd2);
    step();
    instr_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
    begin
      logic seen_done;
      seen_done = done;
      for (int i = 0; i < 4; i++) begin
        step();
        seen_done = seen_done | done;
      end
      chk("mid_rst_no_done", {31'd0, seen_done}, 32'd0);
    end
    for (int i = 0; i < 8; i++) reg_chk($sformatf("mid_rst_r%0d", i), 3'(i), 32'd0);
    chk("mid_rst_flags", {30'd0, carry_flag, zero_flag}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
